itof_issue_unit: RTL and testbench

- Handshaked front end for the integer-to-float converter (itof, fixed 2-stage latency, no stall input).
- Accepts tagged conversion requests from the FPU dispatch stage and streams each request's operand into itof.
- Tracks in-flight requests with a valid/tag shift register and captures every result into a small output FIFO.
- Output feeds writeback. Credit-based admission guarantees no result is dropped while writeback stalls.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_result_fifo.sv | 52 +++++
 rtl/itof.sv | 49 ++++
 rtl/itof_issue_unit.sv | 85 ++++++++
 tb/tb_itof_issue_unit.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: conversion latency, tag width and single-precision field layout.
package fpu_pkg;

    localparam int ITOF_LAT = 2;
    localparam int FPU_TAGW = 5;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpu_result_fifo.sv
// Small result FIFO: DEPTH entries of W bits, head visible combinationally, occupancy count.
module fpu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; storage cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Admission credit must make overflow and underflow impossible.
    no_overflow: assert property (@(posedge clk) disable iff (!rstn) push |-> (count < CW'(DEPTH)));
    no_underflow: assert property (@(posedge clk) disable iff (!rstn) pop |-> (count != '0));

endmodule

// File: rtl/itof.sv
// Signed 32-bit integer to IEEE-754 single converter, NSTAGE register stages, no stall.
// Rounding adds the bit just below the kept mantissa LSB (round half up).
module itof
    import fpu_pkg::*;
#(
    parameter int NSTAGE = ITOF_LAT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic              sign;
    logic [31:0]       mag;
    logic [31:0]       norm;
    logic [4:0]        msb;
    logic [24:0]       rnd;
    logic [EXP_W-1:0]  exp_f;
    logic [31:0]       conv;
    logic [31:0]       stg [NSTAGE];

    // Combinational conversion: magnitude, leading-one search, normalise, round.
    always_comb begin
        sign = x[31];
        mag  = sign ? (~x + 32'd1) : x;
        msb  = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        norm  = mag << (5'd31 - msb);
        rnd   = {1'b0, norm[31:8]} + {24'd0, norm[7]};
        exp_f = EXP_W'(EXP_BIAS) + EXP_W'(msb) + EXP_W'(rnd[24]);
        conv  = (mag == 32'd0) ? FP_POS_ZERO : {sign, exp_f, rnd[MAN_W-1:0]};
    end

    // Result pipeline; contents carry no validity of their own.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NSTAGE; i++) stg[i] <= '0;
        end else begin
            stg[0] <= conv;
            for (int i = 1; i < NSTAGE; i++) stg[i] <= stg[i-1];
        end
    end

    assign y = stg[NSTAGE-1];

endmodule

// File: rtl/itof_issue_unit.sv
// Handshaked front end for itof: tracks in-flight requests and buffers results for writeback.
module itof_issue_unit
    import fpu_pkg::*;
#(
    parameter int LAT   = ITOF_LAT,
    parameter int TAGW  = FPU_TAGW,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [TAGW-1:0] out_tag
);

    localparam int W  = 32 + TAGW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + LAT + 1) + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready; ready never
    // depends on valid, and a producer holds valid/data stable until the transfer.

    logic [LAT-1:0]  vld;
    logic [TAGW-1:0] tag_sr [LAT];
    logic [31:0]     y;
    logic [CW-1:0]   count;
    logic [W-1:0]    head;
    logic [SW-1:0]   occ;
    logic            accept;
    logic            push;
    logic            pop;

    itof #(.NSTAGE(LAT)) u_itof (
        .clk  (clk),
        .rstn (rstn),
        .x    (in_data),
        .y    (y)
    );

    // Credit: buffered plus in-flight results must leave room for every accepted request.
    always_comb begin
        occ = SW'(count);
        for (int i = 0; i < LAT; i++) occ = occ + SW'(vld[i]);
        in_ready = rstn && (occ < SW'(DEPTH));
    end

    assign accept = in_valid && in_ready;
    assign push   = vld[LAT-1];
    assign pop    = out_valid && out_ready;

    // Valid/tag shift register running in lockstep with the itof pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld <= '0;
            for (int i = 0; i < LAT; i++) tag_sr[i] <= '0;
        end else begin
            vld[0] <= accept;
            if (accept) tag_sr[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld[i]    <= vld[i-1];
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    fpu_result_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data ({y, tag_sr[LAT-1]}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign out_data  = head[W-1:TAGW];
    assign out_tag   = head[TAGW-1:0];

endmodule

// File: tb/tb_itof_issue_unit.sv
// Bench for itof_issue_unit: random and directed requests against an arithmetic reference.
module tb_itof_issue_unit;

    localparam int TAGW  = 5;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int W     = 32 + TAGW;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_data = '0;
    logic [TAGW-1:0] in_tag = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [31:0]     out_data;
    logic [TAGW-1:0] out_tag;

    itof_issue_unit #(.LAT(LAT), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_itof(input logic [31:0] x);
        longint m;
        longint q;
        int     e;
        logic   s;
        s = x[31];
        m = longint'($signed(x));
        if (m < 0) m = -m;
        if (m == 0) return 32'h0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e > 23) begin
            q = (m + (longint'(1) << (e - 24))) >> (e - 23);
            if (q == (longint'(1) << 24)) begin
                e++;
                q = q >> 1;
            end
        end else begin
            q = m << (23 - e);
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    logic [31:0]  cur_exp = '0;
    logic [W-1:0] head_e;
    logic         exp_ov;
    int           n_acc = 0;
    int           n_pop = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
            exp_ov = (exp_q.size() > 0) && (cyc >= acc_q[0] + LAT);
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                head_e = exp_q[0];
                chk("out_data", 64'(out_data), 64'(head_e[W-1:TAGW]));
                chk("out_tag", 64'(out_tag), 64'(head_e[TAGW-1:0]));
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
                n_pop++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({cur_exp, in_tag});
                acc_q.push_back(cyc + 1);
                n_acc++;
            end
        end
    end

    // ---------------- drivers ----------------
    int ready_mode = 1;  // 0: stalled, 1: always ready, 2: random

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
            else                 out_ready = (ready_mode == 1);
        end
    end

    task automatic send(input logic [31:0] d, input logic [TAGW-1:0] t, input logic [31:0] e);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        cur_exp  = e;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'(ok), 64'(1));
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 300 && exp_q.size() != 0; w++) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] specials [7];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'hFFFF_FFFF;
        specials[4] = 32'h00FF_FFFF;
        specials[5] = 32'h0100_0003;
        specials[6] = 32'h0100_0001;
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($signed(int'($urandom_range(0, 2000))) - 1000);
            2:       return specials[$urandom_range(0, 6)];
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    // ---------------- main sequence ----------------
    int          base;
    logic [31:0] d;

    initial begin
        // Reset state while rstn is low
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single request
        send(32'h0000_0001, 5'd3, 32'h3F80_0000);
        wait_drain();

        // Back-to-back with out_ready high
        send(32'hFFFF_FFFF, 5'd0, 32'hBF80_0000);
        send(32'h0000_0000, 5'd1, 32'h0000_0000);
        send(32'h8000_0000, 5'd2, 32'hCF00_0000);
        send(32'h7FFF_FFFF, 5'd3, 32'h4F00_0000);
        wait_drain();

        // Rounding cases
        send(32'h0100_0003, 5'd7, 32'h4B80_0002);
        send(32'h00FF_FFFF, 5'd8, 32'h4B7F_FFFF);
        wait_drain();

        // Backpressure: in_valid held high with writeback stalled
        ready_mode = 0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        base     = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d       = rand_operand();
            in_data = d;
            in_tag  = 5'(i + 16);
            cur_exp = ref_itof(d);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepts", 64'(n_acc - base), 64'(DEPTH));
        ready_mode = 1;
        out_ready  = 1'b1;
        wait_drain();

        // Random traffic with random writeback stalls
        ready_mode = 2;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                d = rand_operand();
                send(d, 5'($urandom_range(0, 31)), ref_itof(d));
            end else begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 1;
        wait_drain();
        chk("no_loss", 64'(n_pop), 64'(n_acc));

        // Reset with two results buffered and two in flight
        ready_mode = 0;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            d = 32'(i + 100);
            send(d, 5'(i + 24), ref_itof(d));
        end
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_out_data", 64'(out_data), 64'(0));
        chk("midrst_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        ready_mode = 1;
        out_ready  = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        send(32'hFFFF_FF9C, 5'd9, ref_itof(32'hFFFF_FF9C));
        wait_drain();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
